// File: rtl/i8035_mem_arb.sv
// ---------------------------------------------------------------------------
// i8035_mem_arb
// External bus sequencer for the 8035 sound CPU. It shares one single-port
// external memory between CPU program fetches / MOVX reads and the ROM loader.
// CPU strobes are turned into requests, a req/ack handshake runs to memory,
// and the fetched byte is returned on O_DB.
//
// Ports
//   I_CLK, I_RSTn        clock, asynchronous active-low reset
//   I_ALE, I_PSENn,
//   I_RDn, I_DB, I_P2    CPU bus strobes, multiplexed A7:0 / port 2 (A11:8)
//   O_DB                 byte returned to the CPU data-in bus
//   I_LD_REQ/ADDR/DATA   loader write request (level) with address and data
//   O_LD_ACK             one-cycle pulse when the loader write completes
//   O_MEM_REQ/WE/ADDR/DI memory request, held stable until I_MEM_ACK
//   I_MEM_ACK, I_MEM_DO  memory completion pulse and read data
//   O_LATE               one-cycle pulse when an ack is LATE_CYC cycles late
// ---------------------------------------------------------------------------
module i8035_mem_arb #(
   parameter int LATE_CYC = 24
) (
   input  logic        I_CLK,
   input  logic        I_RSTn,
   input  logic        I_ALE,
   input  logic        I_PSENn,
   input  logic        I_RDn,
   input  logic [7:0]  I_DB,
   input  logic [7:0]  I_P2,
   output logic [7:0]  O_DB,
   input  logic        I_LD_REQ,
   input  logic [12:0] I_LD_ADDR,
   input  logic [7:0]  I_LD_DATA,
   output logic        O_LD_ACK,
   output logic        O_MEM_REQ,
   output logic        O_MEM_WE,
   output logic [12:0] O_MEM_ADDR,
   output logic [7:0]  O_MEM_DI,
   input  logic        I_MEM_ACK,
   input  logic [7:0]  I_MEM_DO,
   output logic        O_LATE
);

   localparam int CNT_W = $clog2(LATE_CYC + 1);
   localparam logic [CNT_W-1:0] LATE_MAX = CNT_W'(LATE_CYC);
   localparam logic [CNT_W-1:0] LATE_PRE = CNT_W'(LATE_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CPU_WAIT,
      S_CPU_HOLD,
      S_LD_WAIT
   } state_t;

   state_t            state;
   logic [7:0]        a_lo;
   logic              psen_p0, psen_p1;
   logic              rd_p0, rd_p1;
   logic              fall_psen, fall_rd, cpu_edge, edge_incoming;
   logic              pend_vld, pend_movx, cur_movx;
   logic [12:0]       pend_addr;
   logic [CNT_W-1:0]  late_cnt;
   logic              unused_p2;

   // Only A11:8 of port 2 reach the memory address.
   assign unused_p2 = ^I_P2[7:4];

   // Edges come from two registered samples so the request is born in a
   // clean cycle; FETCH wins when both strobes fall together.
   assign fall_psen = psen_p1 & ~psen_p0;
   assign fall_rd   = rd_p1 & ~rd_p0;
   assign cpu_edge  = fall_psen | fall_rd;

   // An edge already seen on the pins but not yet registered. The loader is
   // held off while one is in flight so a simultaneous CPU strobe wins.
   assign edge_incoming = (psen_p0 & ~I_PSENn) | (rd_p0 & ~I_RDn);

   // ---- stage p0/p1: address latch and strobe sampling ----
   always_ff @(posedge I_CLK or negedge I_RSTn) begin
      if (!I_RSTn) begin
         a_lo    <= 8'h00;
         psen_p0 <= 1'b1;
         psen_p1 <= 1'b1;
         rd_p0   <= 1'b1;
         rd_p1   <= 1'b1;
      end else begin
         if (I_ALE)
            a_lo <= I_DB;
         psen_p0 <= I_PSENn;
         psen_p1 <= psen_p0;
         rd_p0   <= I_RDn;
         rd_p1   <= rd_p0;
      end
   end

   // Pending address is data only; its valid flag lives with the FSM.
   always_ff @(posedge I_CLK) begin
      if (cpu_edge)
         pend_addr <= {~fall_psen, I_P2[3:0], a_lo};
   end

   // ---- stage p2: arbitration FSM and memory handshake ----
   always_ff @(posedge I_CLK or negedge I_RSTn) begin
      if (!I_RSTn) begin
         state      <= S_IDLE;
         O_DB       <= 8'hFF;
         O_MEM_REQ  <= 1'b0;
         O_MEM_WE   <= 1'b0;
         O_MEM_ADDR <= 13'h0000;
         O_MEM_DI   <= 8'h00;
         O_LD_ACK   <= 1'b0;
         pend_vld   <= 1'b0;
         pend_movx  <= 1'b0;
         cur_movx   <= 1'b0;
      end else begin
         O_LD_ACK <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pend_vld) begin
                  O_MEM_REQ  <= 1'b1;
                  O_MEM_WE   <= 1'b0;
                  O_MEM_ADDR <= pend_addr;
                  cur_movx   <= pend_movx;
                  state      <= S_CPU_WAIT;
               end else if (I_LD_REQ && !cpu_edge && !edge_incoming && !O_LD_ACK) begin
                  // The O_LD_ACK guard gives the loader one cycle to drop
                  // its level request before it could be re-accepted.
                  O_MEM_REQ  <= 1'b1;
                  O_MEM_WE   <= 1'b1;
                  O_MEM_ADDR <= I_LD_ADDR;
                  O_MEM_DI   <= I_LD_DATA;
                  state      <= S_LD_WAIT;
               end
            end
            S_CPU_WAIT: begin
               if (I_MEM_ACK) begin
                  O_DB      <= I_MEM_DO;
                  O_MEM_REQ <= 1'b0;
                  if (cur_movx ? !rd_p0 : !psen_p0)
                     state <= S_CPU_HOLD;
                  else
                     state <= S_IDLE;
               end
            end
            S_CPU_HOLD: begin
               if (psen_p0 && rd_p0)
                  state <= S_IDLE;
            end
            S_LD_WAIT: begin
               if (I_MEM_ACK) begin
                  O_MEM_REQ <= 1'b0;
                  O_LD_ACK  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         // A new edge overwrites the pending slot, even on the issue cycle.
         if (cpu_edge) begin
            pend_vld  <= 1'b1;
            pend_movx <= ~fall_psen;
         end else if (state == S_IDLE && pend_vld) begin
            pend_vld <= 1'b0;
         end
      end
   end

   // Late watchdog: counts request cycles, saturates so it fires once.
   always_ff @(posedge I_CLK or negedge I_RSTn) begin
      if (!I_RSTn) begin
         late_cnt <= '0;
         O_LATE   <= 1'b0;
      end else begin
         O_LATE <= 1'b0;
         if (!O_MEM_REQ || I_MEM_ACK) begin
            late_cnt <= '0;
         end else if (late_cnt != LATE_MAX) begin
            late_cnt <= late_cnt + 1'b1;
            if (late_cnt == LATE_PRE)
               O_LATE <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i8035_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_i8035_mem_arb
// Directed bench for i8035_mem_arb: reset, fetch, MOVX, CPU/loader priority,
// CPU edge during a loader write, late-ack watchdog, back-to-back requests
// and reset in the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_i8035_mem_arb;

   logic        clk;
   logic        rst_n;
   logic        ale, psen_n, rd_n;
   logic [7:0]  db, p2;
   logic [7:0]  o_db;
   logic        ld_req;
   logic [12:0] ld_addr;
   logic [7:0]  ld_data;
   logic        ld_ack;
   logic        mem_req, mem_we;
   logic [12:0] mem_addr;
   logic [7:0]  mem_di;
   logic        mem_ack;
   logic [7:0]  mem_do;
   logic        late;

   int errs   = 0;
   int checks = 0;

   i8035_mem_arb #(.LATE_CYC(24)) dut (
      .I_CLK      (clk),
      .I_RSTn     (rst_n),
      .I_ALE      (ale),
      .I_PSENn    (psen_n),
      .I_RDn      (rd_n),
      .I_DB       (db),
      .I_P2       (p2),
      .O_DB       (o_db),
      .I_LD_REQ   (ld_req),
      .I_LD_ADDR  (ld_addr),
      .I_LD_DATA  (ld_data),
      .O_LD_ACK   (ld_ack),
      .O_MEM_REQ  (mem_req),
      .O_MEM_WE   (mem_we),
      .O_MEM_ADDR (mem_addr),
      .O_MEM_DI   (mem_di),
      .I_MEM_ACK  (mem_ack),
      .I_MEM_DO   (mem_do),
      .O_LATE     (late)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic latch_addr(input logic [7:0] lo, input logic [7:0] hi);
      ale = 1'b1; db = lo; p2 = hi;
      tick();
      ale = 1'b0; db = 8'h00;
      tick();
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (mem_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic pulse_ack(input logic [7:0] d);
      mem_ack = 1'b1; mem_do = d;
      tick();
      mem_ack = 1'b0; mem_do = 8'h00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      checks++; if (o_db !== 8'hFF) begin errs++; $display("FAIL reset_db got=%h exp=ff", o_db); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errs++; $display("FAIL reset_req got=%b%b exp=00", mem_req, mem_we); end
      checks++; if (mem_addr !== 13'h0 || mem_di !== 8'h0) begin errs++; $display("FAIL reset_addr got=%h/%h exp=0/0", mem_addr, mem_di); end
      checks++; if (ld_ack !== 1'b0 || late !== 1'b0) begin errs++; $display("FAIL reset_pulses got=%b%b exp=00", ld_ack, late); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fetch();
      latch_addr(8'h34, 8'h05);
      psen_n = 1'b0;
      tick();  // edge n: low sampled
      checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL fetch_lat_n got=%b exp=0", mem_req); end
      tick();  // n+1
      checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL fetch_lat_n1 got=%b exp=0", mem_req); end
      tick();  // n+2
      checks++; if (mem_req !== 1'b1) begin errs++; $display("FAIL fetch_lat_n2 got=%b exp=1", mem_req); end
      checks++; if (mem_addr !== 13'h0534 || mem_we !== 1'b0) begin errs++; $display("FAIL fetch_addr got=%h we=%b exp=0534 we=0", mem_addr, mem_we); end
      tick(); tick(); tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 13'h0534) begin errs++; $display("FAIL fetch_stable got=%b/%h exp=1/0534", mem_req, mem_addr); end
      pulse_ack(8'hA5);
      checks++; if (o_db !== 8'hA5 || mem_req !== 1'b0) begin errs++; $display("FAIL fetch_data got=%h req=%b exp=a5 req=0", o_db, mem_req); end
      psen_n = 1'b1;
      tick(); tick();
      checks++; if (o_db !== 8'hA5) begin errs++; $display("FAIL fetch_hold got=%h exp=a5", o_db); end
   endtask

   task automatic test_movx();
      bit ok;
      latch_addr(8'h10, 8'h0F);
      rd_n = 1'b0;
      wait_req(ok);
      checks++; if (!ok) begin errs++; $display("FAIL movx_req got=timeout exp=req"); end
      checks++; if (mem_addr !== 13'h1F10 || mem_we !== 1'b0) begin errs++; $display("FAIL movx_addr got=%h we=%b exp=1f10 we=0", mem_addr, mem_we); end
      // Strobe released before the ack: byte is still delivered.
      rd_n = 1'b1;
      tick(); tick();
      checks++; if (mem_req !== 1'b1) begin errs++; $display("FAIL movx_outstanding got=%b exp=1", mem_req); end
      pulse_ack(8'h5A);
      checks++; if (o_db !== 8'h5A || mem_req !== 1'b0) begin errs++; $display("FAIL movx_data got=%h req=%b exp=5a req=0", o_db, mem_req); end
      tick();
   endtask

   task automatic test_priority();
      bit ok;
      int acks;
      latch_addr(8'h22, 8'h03);
      psen_n = 1'b0; ld_req = 1'b1; ld_addr = 13'h0ABC; ld_data = 8'h77;
      wait_req(ok);
      checks++; if (!ok || mem_we !== 1'b0 || mem_addr !== 13'h0322) begin errs++; $display("FAIL prio_cpu_first got=%b we=%b addr=%h exp=1 we=0 addr=0322", ok, mem_we, mem_addr); end
      pulse_ack(8'h11);
      checks++; if (o_db !== 8'h11) begin errs++; $display("FAIL prio_cpu_data got=%h exp=11", o_db); end
      psen_n = 1'b1;
      wait_req(ok);
      checks++; if (!ok || mem_we !== 1'b1 || mem_addr !== 13'h0ABC || mem_di !== 8'h77) begin errs++; $display("FAIL prio_ld got=%b we=%b addr=%h di=%h exp=1 we=1 addr=0abc di=77", ok, mem_we, mem_addr, mem_di); end
      pulse_ack(8'h00);
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         if (ld_ack) acks++;
         ld_req = 1'b0;
         tick();
      end
      checks++; if (acks != 1) begin errs++; $display("FAIL prio_ld_ack got=%0d exp=1", acks); end
      checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL prio_idle got=%b exp=0", mem_req); end
   endtask

   task automatic test_ld_edge();
      bit ok;
      ld_req = 1'b1; ld_addr = 13'h1234; ld_data = 8'h9C;
      wait_req(ok);
      checks++; if (!ok || mem_we !== 1'b1 || mem_addr !== 13'h1234) begin errs++; $display("FAIL ldedge_ld got=%b we=%b addr=%h exp=1 we=1 addr=1234", ok, mem_we, mem_addr); end
      latch_addr(8'h56, 8'h0A);
      psen_n = 1'b0;
      tick(); tick(); tick();
      pulse_ack(8'h00);
      checks++; if (ld_ack !== 1'b1 || mem_req !== 1'b0) begin errs++; $display("FAIL ldedge_ack got=%b req=%b exp=1 req=0", ld_ack, mem_req); end
      ld_req = 1'b0;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 13'h0A56) begin errs++; $display("FAIL ldedge_fetch got=%b we=%b addr=%h exp=1 we=0 addr=0a56", mem_req, mem_we, mem_addr); end
      pulse_ack(8'hC3);
      checks++; if (o_db !== 8'hC3) begin errs++; $display("FAIL ldedge_data got=%h exp=c3", o_db); end
      psen_n = 1'b1;
      tick(); tick();
   endtask

   task automatic test_late();
      bit ok;
      int pulses, at;
      latch_addr(8'h01, 8'h02);
      psen_n = 1'b0;
      wait_req(ok);
      checks++; if (!ok) begin errs++; $display("FAIL late_req got=timeout exp=req"); end
      pulses = 0; at = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (late) begin
            pulses++;
            at = k;
         end
      end
      checks++; if (pulses != 1) begin errs++; $display("FAIL late_count got=%0d exp=1", pulses); end
      checks++; if (at != 24) begin errs++; $display("FAIL late_cycle got=%0d exp=24", at); end
      checks++; if (mem_req !== 1'b1) begin errs++; $display("FAIL late_held got=%b exp=1", mem_req); end
      pulse_ack(8'h3C);
      checks++; if (o_db !== 8'h3C || mem_req !== 1'b0 || late !== 1'b0) begin errs++; $display("FAIL late_done got=%h req=%b late=%b exp=3c 0 0", o_db, mem_req, late); end
      psen_n = 1'b1;
      tick(); tick();
   endtask

   task automatic test_back_to_back();
      bit ok;
      latch_addr(8'h40, 8'h01);
      psen_n = 1'b0;
      wait_req(ok);
      checks++; if (!ok || mem_addr !== 13'h0140) begin errs++; $display("FAIL b2b_first got=%b addr=%h exp=1 addr=0140", ok, mem_addr); end
      psen_n = 1'b1;
      tick();
      latch_addr(8'h41, 8'h01);
      psen_n = 1'b0;
      tick(); tick();
      psen_n = 1'b1;
      tick(); tick();
      pulse_ack(8'hE1);
      checks++; if (o_db !== 8'hE1 || mem_req !== 1'b0) begin errs++; $display("FAIL b2b_gap got=%h req=%b exp=e1 req=0", o_db, mem_req); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 13'h0141) begin errs++; $display("FAIL b2b_second got=%b addr=%h exp=1 addr=0141", mem_req, mem_addr); end
      pulse_ack(8'hE2);
      checks++; if (o_db !== 8'hE2) begin errs++; $display("FAIL b2b_data got=%h exp=e2", o_db); end
      tick();
   endtask

   task automatic test_reset_mid();
      bit ok;
      latch_addr(8'h77, 8'h06);
      psen_n = 1'b0;
      wait_req(ok);
      checks++; if (!ok) begin errs++; $display("FAIL rstmid_req got=timeout exp=req"); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || o_db !== 8'hFF || mem_addr !== 13'h0) begin errs++; $display("FAIL rstmid_async got=%b db=%h addr=%h exp=0 ff 0", mem_req, o_db, mem_addr); end
      tick();
      psen_n = 1'b1;
      rst_n = 1'b1;
      tick();
      pulse_ack(8'h99);
      tick();
      checks++; if (o_db !== 8'hFF || mem_req !== 1'b0) begin errs++; $display("FAIL rstmid_ack_ignored got=%h req=%b exp=ff req=0", o_db, mem_req); end
   endtask

   initial begin
      ale = 1'b0; psen_n = 1'b1; rd_n = 1'b1; db = 8'h00; p2 = 8'h00;
      ld_req = 1'b0; ld_addr = 13'h0; ld_data = 8'h00;
      mem_ack = 1'b0; mem_do = 8'h00;
      rst_n = 1'b0;
      test_reset();
      test_fetch();
      test_movx();
      test_priority();
      test_ld_edge();
      test_late();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/i8035_mem_arb.md
# i8035_mem_arb

Sequences the external bus of the 8035 sound CPU and shares one single-port external memory between it and the ROM loader. It decodes ALE/PSENn/RDn into program-fetch and MOVX-read requests, runs a request/acknowledge handshake to memory, and returns the fetched byte on the CPU data-in bus. It sits between the sound CPU wrapper (DB/P2/strobes) and the board memory controller.

## Interface
- LATE_CYC, 24: cycles from request issue to ack after which O_LATE pulses.
- I_CLK  in  1  system clock, same clock as the sound CPU core.
- I_RSTn  in  1  reset, asynchronous, active-low.
- I_ALE  in  1  CPU address latch enable.
- I_PSENn  in  1  CPU program store enable, active-low.
- I_RDn  in  1  CPU external read strobe, active-low.
- I_DB  in  8  CPU bus output (A7:0 while ALE high).
- I_P2  in  8  CPU port 2 output; [3:0] = A11:8.
- O_DB  out  8  byte to CPU data-in bus.
- I_LD_REQ  in  1  loader write request (level).
- I_LD_ADDR  in  13  loader address.
- I_LD_DATA  in  8  loader write data.
- O_LD_ACK  out  1  one-cycle pulse: loader write completed.
- O_MEM_REQ  out  1  memory request, held until ack.
- O_MEM_WE  out  1  1 = write, 0 = read; valid with O_MEM_REQ.
- O_MEM_ADDR  out  13  memory address; bit 12 = 0 program, 1 data.
- O_MEM_DI  out  8  write data.
- I_MEM_ACK  in  1  one-cycle completion pulse.
- I_MEM_DO  in  8  read data, valid with I_MEM_ACK.
- O_LATE  out  1  one-cycle pulse: ack not received within LATE_CYC.

## Operation
- Address latch: A_LO captures I_DB on every cycle I_ALE=1; frozen when ALE=0. Reset 8'h00.
- Strobe detection: PSENn and RDn registered; falling edge (prev 1, now 0) creates pending CPU request, type FETCH (PSENn) or MOVX (RDn). Both edges same cycle: FETCH wins, MOVX dropped.
- CPU address: FETCH {0, I_P2[3:0], A_LO}; MOVX {1, I_P2[3:0], A_LO}; captured at edge cycle.
- States: IDLE, CPU_WAIT, CPU_HOLD, LD_WAIT.
- IDLE: pending CPU request -> assert O_MEM_REQ (WE=0) next cycle, go CPU_WAIT; else I_LD_REQ=1 -> O_MEM_REQ (WE=1, loader addr/data), go LD_WAIT. CPU request beats loader in same cycle.
- CPU_WAIT: on I_MEM_ACK, O_DB <= I_MEM_DO, drop REQ; go CPU_HOLD if strobe still low, else IDLE.
- CPU_HOLD: wait for both strobes high, then IDLE. O_DB holds.
- LD_WAIT: on I_MEM_ACK, drop REQ, pulse O_LD_ACK, go IDLE. CPU edge arriving here stays pending (one deep) and is served next.
- Strobe released before ack in CPU_WAIT: request stays outstanding until ack; returned byte still loaded into O_DB; then IDLE.
- New CPU edge while one pending: overwrites pending (latest wins).
- Late counter: counts cycles with O_MEM_REQ=1, clears on ack; reaching LATE_CYC pulses O_LATE once per request.
- I_MEM_ACK outside a wait state: ignored.

## Timing
- Reset values: O_DB 8'hFF, O_MEM_REQ 0, O_MEM_WE 0, O_MEM_ADDR 0, O_MEM_DI 0, O_LD_ACK 0, O_LATE 0, state IDLE, pending cleared.
- Reset mid-transaction: REQ drops immediately (async); memory ack after reset ignored.
- Strobe fall at cycle n (sampled): O_MEM_REQ high at n+2 from IDLE.
- Ack at cycle m: O_DB valid and REQ low at m+1.
- O_MEM_ADDR/WE/DI stable for whole REQ duration.
- Back-to-back: min 1 idle cycle between REQ deassert and next REQ.

## Test plan
- Reset: hold I_RSTn=0 mid-REQ -> all outputs at reset values same cycle, O_DB=8'hFF.
- Fetch: ALE with DB=8'h34, P2=8'h05, PSENn falls, ack after 3 cycles with 8'hA5 -> O_MEM_ADDR=13'h0534, WE=0, O_DB=8'hA5.
- MOVX: DB=8'h10, P2=8'h0F, RDn falls -> O_MEM_ADDR=13'h1F10, data returned on O_DB.
- Priority: loader REQ and PSENn edge same cycle -> CPU served first, then loader write, one O_LD_ACK pulse.
- Edge during LD_WAIT: fetch issued the cycle after loader ack+idle, correct address.
- Late: ack withheld 30 cycles with LATE_CYC=24 -> single O_LATE pulse at cycle 24, REQ held until ack.
